// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register (hold, shift right/left,
//   parallel load, synchronous clear) with a saturating fill counter.
// Latency: stage updates land one enabled clk edge after the request; sout is
//   combinational from the stages and mode only. No backpressure; en gates every update.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   en, clr         clock enable; synchronous clear (only acts when en=1)
//   mode            00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin, rot        serial input; rotate request
//   pin, pout       parallel in/out, stage i at [i*WIDTH +: WIDTH]
//   sout            stage DEPTH-1 in right mode, stage 0 otherwise
//   fill_cnt, full  number of valid stages (0..DEPTH); fill_cnt == DEPTH
//
// Build option: define SHIFT_ROTATE_EN so that rot=1 turns a shift into a rotate
// (the outgoing stage re-enters at the other end, fill_cnt untouched). Without
// the macro rot is ignored and shifts always take sin.

module shift_reg_univ #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin,
  input  logic                   rot,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [WIDTH-1:0]       sout,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef logic [WIDTH-1:0] stage_t;

  // Packed so that element i occupies bits [i*WIDTH +: WIDTH], matching pin/pout.
  stage_t [DEPTH-1:0] stage_q, stage_d;
  logic   [CW-1:0]    cnt_q, cnt_d;
  logic   [CW-1:0]    cnt_inc;
  logic               rot_take;

`ifdef SHIFT_ROTATE_EN
  assign rot_take = rot;
`else
  // rot stays on the port so both builds share one interface.
  logic rot_unused;
  assign rot_unused = rot;
  assign rot_take   = 1'b0;
`endif

  // Saturating increment: the counter never wraps past DEPTH.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (en) begin
      if (clr) begin
        stage_d = '0;
        cnt_d   = '0;
      end else begin
        case (mode)
          MODE_RIGHT: begin
            for (int i = 1; i < DEPTH; i++) begin
              stage_d[i] = stage_q[i-1];
            end
            stage_d[0] = rot_take ? stage_q[DEPTH-1] : sin;
            // A rotate brings no new data in, so the fill level stays put.
            if (!rot_take) cnt_d = cnt_inc;
          end
          MODE_LEFT: begin
            for (int i = 0; i < DEPTH - 1; i++) begin
              stage_d[i] = stage_q[i+1];
            end
            stage_d[DEPTH-1] = rot_take ? stage_q[0] : sin;
            if (!rot_take) cnt_d = cnt_inc;
          end
          MODE_LOAD: begin
            stage_d = pin;
            cnt_d   = CNT_MAX;
          end
          MODE_HOLD: begin
            stage_d = stage_q;
          end
          default: begin
            stage_d = stage_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pout     = stage_q;
  // Right mode drains from the top stage; every other mode presents stage 0.
  assign sout     = (mode == MODE_RIGHT) ? stage_q[DEPTH-1] : stage_q[0];
  assign fill_cnt = cnt_q;
  assign full     = (cnt_q == CNT_MAX);

endmodule
